imem_responder: RTL and testbench

- Instruction-memory responder that serves the fetch stage's PC requests.
- Accepts one fetch address at a time through a valid/ready request channel.
- Models a configurable number of wait states, then returns the 32-bit instruction word on a valid/ready response channel.
- Includes a word-wide loader port so benches and boot logic can preload program contents.

---
 rtl/imem_responder_if.sv | 23 ++
 rtl/imem_responder.sv | 86 ++++++++
 tb/tb_imem_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-side request/response bus between the fetch stage and the instruction memory.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  // Fetch stage: issues PCs and consumes instruction words.
  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );

  // Instruction memory: accepts PCs and returns instruction words.
  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, WAIT_CYCLES wait states,
// a registered lookup, and a held response. A word-wide loader port can preload
// the program at any time.
module imem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_responder_if.slave          bus,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [DEPTH];

  // Lookup on the latched address. The offset is computed one bit wider so an
  // address below BASE_ADDR shows up as a borrow instead of wrapping into range.
  logic [32:0] off;
  logic [31:0] idx;
  logic        fault;
  always_comb begin
    off   = {1'b0, bus.rsp_addr} - {1'b0, BASE_ADDR};
    idx   = off[31:0] >> 2;
    fault = (bus.rsp_addr[1:0] != 2'b00) || off[32] || (idx >= 32'(DEPTH));
  end

  // Ready only in IDLE, and held low for the whole time reset is asserted.
  assign bus.req_ready = (state == IDLE) && !rst;

  // Loader write port; memory is never reset so a preloaded program survives rst.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Fetch FSM. WAIT always runs one more cycle than WAIT_CYCLES: that final cycle
  // is the registered lookup edge, so the response appears WAIT_CYCLES+1 edges
  // after acceptance (also when WAIT_CYCLES is 0). The lookup reads mem with a
  // non-blocking write pending, so a same-edge loader write returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_inst  <= '0;
      bus.rsp_addr  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.rsp_addr <= bus.req_addr;
            cnt          <= CW'(WAIT_CYCLES);
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= fault;
            bus.rsp_inst  <= fault ? NOP : mem[idx[AW-1:0]];
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (W=2/base 0, W=0/base 0, W=2/base 0x1000)
// driven by directed steps; expected responses go through a scoreboard queue.
module tb_imem_responder;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic        rsp_ready [3];
  logic        ld_en     [3];
  logic [9:0]  ld_addr   [3];
  logic [31:0] ld_data   [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_inst  [3];
  logic [31:0] rsp_addr  [3];
  logic        rsp_err   [3];

  logic [31:0] mdl [3][DEPTH];
  exp_t        sb  [3][$];

  imem_responder_if if0 ();
  imem_responder_if if1 ();
  imem_responder_if if2 ();

  assign if0.req_valid = req_valid[0]; assign if0.req_addr = req_addr[0]; assign if0.rsp_ready = rsp_ready[0];
  assign if1.req_valid = req_valid[1]; assign if1.req_addr = req_addr[1]; assign if1.rsp_ready = rsp_ready[1];
  assign if2.req_valid = req_valid[2]; assign if2.req_addr = req_addr[2]; assign if2.rsp_ready = rsp_ready[2];
  assign req_ready[0] = if0.req_ready; assign rsp_valid[0] = if0.rsp_valid; assign rsp_inst[0] = if0.rsp_inst;
  assign rsp_addr[0]  = if0.rsp_addr;  assign rsp_err[0]   = if0.rsp_err;
  assign req_ready[1] = if1.req_ready; assign rsp_valid[1] = if1.rsp_valid; assign rsp_inst[1] = if1.rsp_inst;
  assign rsp_addr[1]  = if1.rsp_addr;  assign rsp_err[1]   = if1.rsp_err;
  assign req_ready[2] = if2.req_ready; assign rsp_valid[2] = if2.rsp_valid; assign rsp_inst[2] = if2.rsp_inst;
  assign rsp_addr[2]  = if2.rsp_addr;  assign rsp_err[2]   = if2.rsp_err;

  imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));
  imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));
  imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_1000)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .ld_en(ld_en[2]), .ld_addr(ld_addr[2]), .ld_data(ld_data[2]));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference lookup, written from the address-map rules.
  function automatic exp_t model(int k, logic [31:0] a);
    exp_t        e;
    logic [31:0] base;
    base   = (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
    e.addr = a;
    if (a[1:0] != 2'b00 || a < base || ((a - base) / 4) >= DEPTH) begin
      e.err  = 1'b1;
      e.inst = 32'h0000_0013;
    end else begin
      e.err  = 1'b0;
      e.inst = mdl[k][(a - base) / 4];
    end
    return e;
  endfunction

  task automatic load(int k, int idx, logic [31:0] d);
    ld_en[k] = 1'b1; ld_addr[k] = 10'(idx); ld_data[k] = d;
    step();
    ld_en[k] = 1'b0;
    mdl[k][idx] = d;
  endtask

  task automatic pop_cmp(int k, string tag);
    exp_t e;
    checks++;
    assert (sb[k].size() > 0) else begin
      errors++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end
    if (sb[k].size() > 0) begin
      e = sb[k].pop_front();
      chk({tag, ".inst"}, rsp_inst[k], e.inst);
      chk({tag, ".addr"}, rsp_addr[k], e.addr);
      chk({tag, ".err"},  32'(rsp_err[k]), 32'(e.err));
    end
  endtask

  // Full fetch with rsp_ready held high: accept, measure latency, compare, handshake.
  task automatic fetch(int k, logic [31:0] a, int lat_exp, string tag);
    int lat;
    sb[k].push_back(model(k, a));
    rsp_ready[k] = 1'b1;
    req_valid[k] = 1'b1; req_addr[k] = a;
    chk({tag, ".req_ready"}, 32'(req_ready[k]), 32'd1);
    step();
    req_valid[k] = 1'b0; req_addr[k] = $urandom;
    lat = 0;
    do begin step(); lat++; end while (!rsp_valid[k] && lat < 20);
    chk({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    pop_cmp(k, tag);
    step();
    chk({tag, ".valid_drop"}, 32'(rsp_valid[k]), 32'd0);
    chk({tag, ".idle_ready"}, 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    logic [31:0] h_inst, h_addr;
    int          seen;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b1;
      ld_en[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
    end

    // Reset state
    #12;
    chk("rst.req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst.rsp_inst",  rsp_inst[0], 32'd0);
    chk("rst.rsp_addr",  rsp_addr[0], 32'd0);
    chk("rst.rsp_err",   32'(rsp_err[0]), 32'd0);
    rst = 1'b0;
    step();
    chk("rel.req_ready", 32'(req_ready[0]), 32'd1);

    // Preload program into all instances
    for (int k = 0; k < 3; k++) begin
      load(k, 0, 32'h0050_0093);
      load(k, 1, 32'h0000_0463);
    end

    // Basic fetches, W=2
    fetch(0, 32'h0000_0000, 3, "f0");
    fetch(0, 32'h0000_0004, 3, "f4");

    // Stall in RESP for 5 cycles; stray request and loader write must not disturb it
    sb[0].push_back(model(0, 32'h0000_0000));
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0000;
    step();
    req_valid[0] = 1'b0;
    seen = 0;
    do begin step(); seen++; end while (!rsp_valid[0] && seen < 20);
    chk("stall.latency", 32'(seen), 32'd3);
    h_inst = rsp_inst[0]; h_addr = rsp_addr[0];
    pop_cmp(0, "stall");
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0008; end
      if (c == 2) begin req_valid[0] = 1'b0; ld_en[0] = 1'b1; ld_addr[0] = 10'd0; ld_data[0] = 32'hDEAD_BEEF; end
      if (c == 3) ld_en[0] = 1'b0;
      step();
      chk("stall.valid", 32'(rsp_valid[0]), 32'd1);
      chk("stall.inst",  rsp_inst[0], h_inst);
      chk("stall.addr",  rsp_addr[0], h_addr);
      chk("stall.ready", 32'(req_ready[0]), 32'd0);
    end
    mdl[0][0] = 32'hDEAD_BEEF;
    rsp_ready[0] = 1'b1;
    step();
    chk("stall.release_valid", 32'(rsp_valid[0]), 32'd0);
    chk("stall.release_ready", 32'(req_ready[0]), 32'd1);
    chk("stall.no_extra", 32'(sb[0].size()), 32'd0);
    load(0, 0, 32'h0050_0093);

    // Faults: misaligned and out of range
    fetch(0, 32'h0000_0002, 3, "misal");
    fetch(0, 32'h0000_1000, 3, "oor");

    // W=0: latency 1, same-edge loader write returns old data
    fetch(1, 32'h0000_0004, 1, "w0");
    sb[1].push_back(model(1, 32'h0000_0000));
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_addr[1] = 32'h0000_0000;
    step();
    req_valid[1] = 1'b0;
    ld_en[1] = 1'b1; ld_addr[1] = 10'd0; ld_data[1] = 32'h1234_5678;
    step();
    ld_en[1] = 1'b0;
    mdl[1][0] = 32'h1234_5678;
    chk("w0.same_edge_valid", 32'(rsp_valid[1]), 32'd1);
    pop_cmp(1, "w0.same_edge");
    step();
    chk("w0.same_edge_drop", 32'(rsp_valid[1]), 32'd0);
    fetch(1, 32'h0000_0000, 1, "w0.new");

    // Async reset mid-WAIT abandons the request
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0000;
    step();
    req_valid[0] = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("arst.req_ready", 32'(req_ready[0]), 32'd0);
    #10 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rsp_valid[0]) seen++;
    end
    chk("arst.no_rsp", 32'(seen), 32'd0);
    fetch(0, 32'h0000_0004, 3, "arst.f4");

    // BASE_ADDR=0x1000
    fetch(2, 32'h0000_0FFC, 3, "base.below");
    fetch(2, 32'h0000_1000, 3, "base.w0");
    fetch(2, 32'h0000_1004, 3, "base.w1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
